// File: rtl/bcd_calc_n_pkg.sv
// Shared types and constants for the N-digit BCD button calculator.
// Holds the FSM states, op encoding, display codes and width helper.
package bcd_calc_n_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENTER_A,
      ENTER_B,
      COMPUTE,
      CONVERT,
      SHOW
   } state_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   localparam logic [3:0] BLANK = 4'd10;
   localparam logic [3:0] MINUS = 4'd11;

   // Bits needed to hold 2*(10^n_dig - 1), the largest possible sum.
   function automatic int rw_of(input int n_dig);
      longint unsigned maxv;
      int w;
      maxv = 1;
      for (int i = 0; i < n_dig; i++) maxv = maxv * 10;
      maxv = 2 * (maxv - 1);
      w = 0;
      for (int i = 0; i < 64; i++)
         if ((maxv >> i) != 0) w = i + 1;
      return w;
   endfunction

endpackage

// File: rtl/bcd_calc_n_bin2bcd_seq.sv
// Iterative double-dabble: one shift-add-3 step per cycle, RW steps.
// done is high during the final step; bcd holds the result afterwards.
module bin2bcd_seq #(
   parameter int RW = 11,
   parameter int ND = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [RW-1:0]   bin,
   output logic [4*ND-1:0] bcd,
   output logic            done
);

   localparam int CW = $clog2(RW + 1);

   logic [RW-1:0]   sh;
   logic [CW-1:0]   cnt;
   logic [4*ND-1:0] adj;

   always_comb begin
      adj = bcd;
      for (int k = 0; k < ND; k++)
         if (bcd[4*k +: 4] >= 4'd5)
            adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
   end

   assign done = (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         sh  <= '0;
         cnt <= '0;
         bcd <= '0;
      end else if (start) begin
         sh  <= bin;
         cnt <= CW'(RW);
         bcd <= '0;
      end else if (cnt != '0) begin
         bcd <= {adj[4*ND-2:0], sh[RW-1]};
         sh  <= sh << 1;
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/bcd_calc_n.sv
// Button-driven N-digit BCD add/subtract calculator with sign display.
// Operands are entered digit by digit, result shown after conversion.
module bcd_calc_n
   import bcd_calc_n_pkg::*;
#(
   parameter int N_DIG = 3,
   parameter int RW    = rw_of(N_DIG)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   plus,
   input  logic                   minus,
   input  logic                   calc,
   input  logic [N_DIG-1:0]       inc,
   output logic [4*(N_DIG+2)-1:0] disp,
   output logic                   busy,
   output logic                   res_valid
);

   localparam int ND = N_DIG + 1;

   state_t state;
   op_t    op;

   logic [RW-1:0] a;
   logic [RW-1:0] b;
   logic [RW-1:0] entry;
   logic [RW-1:0] mag;
   logic          neg;
   logic          neg_next;

   logic [N_DIG-1:0][3:0] dig;
   logic [N_DIG-1:0][3:0] dig_inc;

   logic             arm;
   logic             plus_q;
   logic             minus_q;
   logic             calc_q;
   logic [N_DIG-1:0] inc_q;

   logic             ev_plus;
   logic             ev_minus;
   logic             ev_calc;
   logic             ev_op;
   logic [N_DIG-1:0] ev_inc;
   op_t              op_sel;

   logic            cv_start;
   logic            cv_done;
   logic [4*ND-1:0] bcd;

   // arm masks the first cycle after reset so held buttons stay silent
   assign ev_plus  = arm & plus & ~plus_q;
   assign ev_minus = arm & minus & ~minus_q;
   assign ev_calc  = arm & calc & ~calc_q;
   assign ev_inc   = {N_DIG{arm}} & inc & ~inc_q;
   assign ev_op    = ev_plus | ev_minus;
   assign op_sel   = ev_plus ? OP_ADD : OP_SUB;

   always_comb begin
      entry = '0;
      for (int i = N_DIG - 1; i >= 0; i--)
         entry = entry * RW'(10) + RW'(dig[i]);
   end

   always_comb begin
      dig_inc = dig;
      for (int i = 0; i < N_DIG; i++)
         if (ev_inc[i])
            dig_inc[i] = (dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1;
   end

   always_comb begin
      neg_next = 1'b0;
      if (op == OP_ADD) begin
         mag = a + b;
      end else if (a < b) begin
         mag      = b - a;
         neg_next = 1'b1;
      end else begin
         mag = a - b;
      end
   end

   assign cv_start = (state == COMPUTE);

   bin2bcd_seq #(
      .RW(RW),
      .ND(ND)
   ) u_conv (
      .clk  (clk),
      .rst  (rst),
      .start(cv_start),
      .bin  (mag),
      .bcd  (bcd),
      .done (cv_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op      <= OP_ADD;
         a       <= '0;
         b       <= '0;
         neg     <= 1'b0;
         dig     <= '0;
         arm     <= 1'b0;
         plus_q  <= 1'b0;
         minus_q <= 1'b0;
         calc_q  <= 1'b0;
         inc_q   <= '0;
      end else begin
         arm     <= 1'b1;
         plus_q  <= plus;
         minus_q <= minus;
         calc_q  <= calc;
         inc_q   <= inc;
         unique case (state)
            IDLE: begin
               if (ev_op) begin
                  op    <= op_sel;
                  dig   <= '0;
                  state <= ENTER_A;
               end
            end
            ENTER_A: begin
               if (ev_calc) begin
                  a     <= entry;
                  dig   <= '0;
                  state <= ENTER_B;
               end else begin
                  dig <= dig_inc;
               end
            end
            ENTER_B: begin
               if (ev_calc) begin
                  b     <= entry;
                  state <= COMPUTE;
               end else begin
                  dig <= dig_inc;
               end
            end
            COMPUTE: begin
               neg   <= neg_next;
               state <= CONVERT;
            end
            CONVERT: begin
               if (cv_done) state <= SHOW;
            end
            SHOW: begin
               if (ev_calc) begin
                  state <= IDLE;
               end else if (ev_op) begin
                  op    <= op_sel;
                  dig   <= '0;
                  state <= ENTER_A;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state == COMPUTE) || (state == CONVERT);
   assign res_valid = (state == SHOW);

   always_comb begin
      disp = {(N_DIG+2){BLANK}};
      case (state)
         ENTER_A, ENTER_B: begin
            for (int i = 0; i < N_DIG; i++)
               disp[4*i +: 4] = dig[i];
         end
         SHOW: begin
            for (int k = 0; k < ND; k++)
               disp[4*k +: 4] = bcd[4*k +: 4];
            disp[4*ND +: 4] = neg ? MINUS : BLANK;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bcd_calc_n.sv
// Scoreboard bench for bcd_calc_n: random operations against an
// arithmetic reference, plus entry, priority and reset corner cases.
module tb_bcd_calc_n;

   localparam int N   = 3;
   localparam int RW  = 11;
   localparam int DW  = 4 * (N + 2);
   localparam int LAT = RW + 2;
   localparam logic [DW-1:0] ALL_BLANK = {(N+2){4'd10}};

   typedef struct {
      logic [DW-1:0] disp;
      int            cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          plus = 1'b0;
   logic          minus = 1'b0;
   logic          calc = 1'b0;
   logic [N-1:0]  inc = '0;
   logic [DW-1:0] disp;
   logic          busy;
   logic          res_valid;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   bit   rv_prev = 1'b0;

   bcd_calc_n #(.N_DIG(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .plus     (plus),
      .minus    (minus),
      .calc     (calc),
      .inc      (inc),
      .disp     (disp),
      .busy     (busy),
      .res_valid(res_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", nm, act, want);
      end
   endtask

   function automatic logic [DW-1:0] show_code(input int r, input bit ng);
      logic [DW-1:0] d;
      int p;
      d = '0;
      p = 1;
      for (int k = 0; k <= N; k++) begin
         d[4*k +: 4] = 4'((r / p) % 10);
         p = p * 10;
      end
      d[4*(N+1) +: 4] = ng ? 4'd11 : 4'd10;
      return d;
   endfunction

   function automatic logic [DW-1:0] entry_code(input int v);
      logic [DW-1:0] d;
      int p;
      d = ALL_BLANK;
      p = 1;
      for (int k = 0; k < N; k++) begin
         d[4*k +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return d;
   endfunction

   // Monitor: each new SHOW entry pops one expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (res_valid && !rv_prev) begin
            if (sbq.size() == 0) begin
               check("queue_nonempty", 32'(sbq.size()), 1);
            end else begin
               e = sbq.pop_front();
               check("result_disp", disp, e.disp);
               check("result_latency", cyc, e.cyc);
            end
         end
         rv_prev = res_valid;
      end
   end

   task automatic press_op(input bit sub, input bit both);
      plus  = !sub || both;
      minus = sub || both;
      @(negedge clk);
      plus  = 1'b0;
      minus = 1'b0;
      @(negedge clk);
   endtask

   task automatic press_calc();
      calc = 1'b1;
      @(negedge clk);
      calc = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_inc(input logic [N-1:0] m);
      inc = m;
      @(negedge clk);
      inc = '0;
      @(negedge clk);
   endtask

   task automatic enter_num(input int v, input string nm);
      int d[N];
      int p;
      logic [N-1:0] m;
      p = 1;
      for (int i = 0; i < N; i++) begin
         d[i] = (v / p) % 10;
         p = p * 10;
      end
      for (int k = 0; k < 9; k++) begin
         m = '0;
         for (int i = 0; i < N; i++)
            if (d[i] > k) m[i] = 1'b1;
         if (m != '0) pulse_inc(m);
      end
      check(nm, disp, entry_code(v));
   endtask

   task automatic finish_op(input int a, input int b, input bit sub,
                            input bit calc_mid);
      int   r;
      bit   ng;
      bit   ok;
      exp_t e;
      enter_num(b, "entry_b");
      ng = 1'b0;
      if (!sub) r = a + b;
      else if (a < b) begin
         r  = b - a;
         ng = 1'b1;
      end else r = a - b;
      calc = 1'b1;
      e.disp = show_code(r, ng);
      e.cyc  = cyc + LAT;
      sbq.push_back(e);
      @(negedge clk);
      calc = 1'b0;
      check("busy_compute", busy, 1);
      if (calc_mid) begin
         repeat (3) @(negedge clk);
         calc = 1'b1;
         @(negedge clk);
         calc = 1'b0;
      end
      ok = 1'b0;
      for (int i = 0; i < 4 * LAT; i++) begin
         if (res_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("show_reached", ok, 1);
   endtask

   task automatic run_op(input int a, input int b, input bit sub,
                         input bit both, input bit calc_mid);
      press_op(sub, both);
      enter_num(a, "entry_a");
      press_calc();
      finish_op(a, b, sub && !both, calc_mid);
   endtask

   initial begin
      int ra;
      int rb;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_disp", disp, ALL_BLANK);
      check("rst_busy", busy, 0);
      check("rst_valid", res_valid, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_disp", disp, ALL_BLANK);

      press_calc();
      pulse_inc(1);
      check("idle_ignore", disp, ALL_BLANK);

      run_op(123, 456, 0, 0, 0);
      run_op(999, 999, 0, 0, 0);
      run_op(100, 250, 1, 0, 0);
      run_op(250, 250, 1, 0, 0);
      press_calc();
      check("show_to_idle", disp, ALL_BLANK);

      run_op(5, 3, 1, 1, 1);

      press_op(0, 0);
      repeat (10) pulse_inc(1);
      check("inc_wrap", disp, entry_code(0));
      inc = 1;
      repeat (20) @(negedge clk);
      inc = '0;
      @(negedge clk);
      check("inc_held", disp, entry_code(1));
      pulse_inc(3'b101);
      check("inc_multi", disp, entry_code(102));
      press_calc();
      finish_op(102, 7, 0, 0);

      repeat (25) begin
         ra = $urandom_range(0, 999);
         rb = $urandom_range(0, 999);
         run_op(ra, rb, 1'($urandom_range(0, 1)), 0,
                1'($urandom_range(0, 1)));
      end

      press_op(0, 0);
      enter_num(321, "entry_a");
      press_calc();
      enter_num(45, "entry_b");
      calc = 1'b1;
      @(negedge clk);
      calc = 1'b0;
      repeat (5) @(negedge clk);
      check("busy_convert", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_disp", disp, ALL_BLANK);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_valid", res_valid, 0);

      plus = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("held_plus_idle", disp, ALL_BLANK);
      plus = 1'b0;
      @(negedge clk);

      run_op(7, 9, 1, 0, 0);
      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sbq.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
